// File: rtl/twiddle_addr_gen.sv
// twiddle_addr_gen: radix-2 in-place FFT butterfly sequencer.
// Issues stage, twiddle index and operand addresses per butterfly.
module twiddle_addr_gen #(
   parameter int LOG2N = 3,
   parameter int SW    = 3
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             dif_mode,
   input  logic             clear,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [SW-1:0]    stage_count_out,
   output logic [LOG2N-2:0] bfly_idx,
   output logic [LOG2N-2:0] index_val,
   output logic [LOG2N-1:0] addr_top,
   output logic [LOG2N-1:0] addr_bot,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int BW = LOG2N - 1;
   localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
   localparam logic [BW-1:0]    B_LAST = '1;
   localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] s_q, s_nxt;
   logic [BW-1:0] b_q, b_nxt;
   logic          dif_q, dif_nxt;
   logic          run;
   logic          final_beat;

   assign run        = (state == RUN);
   assign final_beat = (s_q == S_LAST) && (b_q == B_LAST);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= IDLE;
         s_q   <= '0;
         b_q   <= '0;
         dif_q <= 1'b0;
      end else begin
         state <= state_nxt;
         s_q   <= s_nxt;
         b_q   <= b_nxt;
         dif_q <= dif_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_nxt     = s_q;
      b_nxt     = b_q;
      dif_nxt   = dif_q;
      if (clear) begin
         state_nxt = IDLE;
         s_nxt     = '0;
         b_nxt     = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = RUN;
                  dif_nxt   = dif_mode;
                  s_nxt     = '0;
                  b_nxt     = '0;
               end
            end
            RUN: begin
               if (out_ready) begin
                  // b is exactly BW bits wide, so it wraps on its own
                  b_nxt = b_q + BW'(1);
                  if (b_q == B_LAST)
                     s_nxt = s_q + SW'(1);
                  if (final_beat) begin
                     state_nxt = DONE;
                     s_nxt     = '0;
                  end
               end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   logic [SW-1:0]    sh, ksh;
   logic [BW-1:0]    mask, pos, hi, kx;
   logic [LOG2N-1:0] top, bot;

   // top address = b with a zero bit inserted at the span position
   always_comb begin
      sh   = dif_q ? (S_LAST - s_q) : s_q;
      ksh  = dif_q ? s_q : (S_LAST - s_q);
      mask = ~(B_LAST << sh);
      pos  = b_q & mask;
      hi   = b_q & ~mask;
      top  = {hi, 1'b0} | {1'b0, pos};
      bot  = top | (ONE << sh);
      kx   = pos << ksh;
   end

   assign out_valid       = run;
   assign stage_count_out = run ? s_q : '0;
   assign bfly_idx        = run ? b_q : '0;
   assign index_val       = run ? kx : '0;
   assign addr_top        = run ? top : '0;
   assign addr_bot        = run ? bot : '0;
   assign last            = run && final_beat;
   assign busy            = (state != IDLE);
   assign done            = (state == DONE);

endmodule

// File: doc/twiddle_addr_gen.md
Name: twiddle_addr_gen

Overview:
- Parametrised radix-2 FFT sequencer for an N = 2^LOG2N point in-place transform.
- Walks every butterfly of every stage and issues, per butterfly:
  - the stage number;
  - the twiddle ROM index;
  - the top and bottom data-RAM addresses.
- Supports DIT or DIF ordering, selected per transform.
- Sits between the FFT control FSM and the twiddle ROM / butterfly datapath, using a valid/ready output handshake.

Parameters:
- LOG2N, 3, log2 of FFT size; legal range 2..12. N = 2^LOG2N.
- SW, 3, width of the stage counter; must satisfy 2^SW > LOG2N-1.

Ports:
- clk, input, 1, system clock, rising edge.
- nrst, input, 1, asynchronous active-low reset.
- start, input, 1, begin a transform; sampled only in IDLE.
- dif_mode, input, 1, 0 = DIT, 1 = DIF; latched when start is accepted.
- clear, input, 1, synchronous abort; highest priority after reset.
- out_ready, input, 1, downstream accepts the current beat.
- out_valid, output, 1, beat fields are valid.
- stage_count_out, output, SW, current stage s, range 0..LOG2N-1.
- bfly_idx, output, LOG2N-1, butterfly b within stage, range 0..N/2-1.
- index_val, output, LOG2N-1, twiddle index k (W_N^k).
- addr_top, output, LOG2N, top operand address.
- addr_bot, output, LOG2N, bottom operand address.
- last, output, 1, high with the final beat of the transform.
- busy, output, 1, high in RUN or DONE.
- done, output, 1, one-cycle pulse after the final beat transfers.

Behaviour:
- Reset (nrst=0, asynchronous):
  - state = IDLE; all outputs 0; latched mode = DIT.
- States: IDLE, RUN, DONE.
  - IDLE:
    - start=1 && clear=0 at a posedge: latch dif_mode, s=0, b=0, go to RUN.
    - out_valid rises in the next cycle, so latency is 1 cycle from start to the first beat.
  - RUN:
    - out_valid=1.
    - A transfer occurs on a posedge with out_valid && out_ready.
    - On transfer, b increments. When b = N/2-1, b wraps to 0 and s increments.
    - The transfer with s = LOG2N-1 and b = N/2-1 goes to DONE.
    - Without out_ready, all outputs hold stable (no change while stalled).
  - DONE:
    - done=1 and out_valid=0 for exactly one cycle, then IDLE.
- start handling:
  - Ignored in RUN and DONE; no queuing.
  - start in the same cycle the FSM returns to IDLE is not seen; the FSM must be in IDLE when start is sampled.
- clear:
  - In any state, next state = IDLE, with no done pulse.
  - clear overrides start in the same cycle.
- Arithmetic, per beat:
  - DIT:
    - span = 2^s; grp = b >> s; pos = b mod 2^s.
    - k = pos << (LOG2N-1-s).
  - DIF:
    - span = 2^(LOG2N-1-s); grp = b >> (LOG2N-1-s); pos = b mod span.
    - k = pos << s.
  - Both modes: addr_top = grp*2*span + pos; addr_bot = addr_top + span.
  - All fields are unsigned and cannot overflow their widths.
- Output gating:
  - last = out_valid && s = LOG2N-1 && b = N/2-1.
  - When out_valid=0, stage_count_out, bfly_idx, index_val, addr_top, addr_bot and last read 0.
- Beat count:
  - Total beats per transform = LOG2N*N/2 (12 for the default).
  - Exactly one done pulse per completed transform.
- Outputs may be combinational from registered state and counters, but must be glitch-free relative to clk, i.e. no combinational path from any input to any output.

Test Plan:
- Reset, then DIT start with out_ready held high (LOG2N=3) -> 12 consecutive beats:
  - stage 0: k = 0,0,0,0; addresses (0,1),(2,3),(4,5),(6,7).
  - stage 1: k = 0,2,0,2; addresses (0,2),(1,3),(4,6),(5,7).
  - stage 2: k = 0,1,2,3; addresses (0,4),(1,5),(2,6),(3,7).
  - last on beat 12, done the cycle after, busy low the cycle after that.
- DIF start -> 12 consecutive beats:
  - stage 0: k = 0,1,2,3; addresses (0,4)..(3,7).
  - stage 1: k = 0,2,0,2; addresses (0,2),(1,3),(4,6),(5,7).
  - stage 2: k = 0; addresses (0,1)..(6,7).
- Backpressure: out_ready low for 3 cycles on beat s=1, b=1 -> stage=1, k=2, (1,3) held for 4 cycles; sequence then resumes unchanged, still 12 transfers total.
- start pulsed mid-RUN and during DONE -> ignored: no restart, single done pulse.
- clear asserted at s=1, b=2 (same cycle as start=1) -> IDLE next cycle, out_valid=0, no done; a later start begins from s=0, b=0.
- nrst asserted mid-RUN -> all outputs 0 immediately (asynchronous); after release, IDLE until start.
